// File: rtl/postage_maxi_mul_acc_pipe.sv
// Pipelined parametrised multiplier with a saturating run accumulator on the output stage.
// Results leave in sample order, NUM_STAGE enabled cycles after the closing sample.
module postage_maxi_mul_acc_pipe #(
  parameter int DIN0_WIDTH  = 16,
  parameter int DIN1_WIDTH  = 9,
  parameter int DIN0_SIGNED = 0,
  parameter int DIN1_SIGNED = 0,
  parameter int NUM_STAGE   = 4,
  parameter int ACC_WIDTH   = 32,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ce,
  input  logic                  din_valid,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  din_acc,
  input  logic                  din_last,
  output logic [ACC_WIDTH-1:0]  dout,
  output logic                  dout_valid,
  output logic [CNT_WIDTH-1:0]  dout_cnt,
  output logic                  dout_ovf
);

  // Handshake: a sample is taken when din_valid=1 at an edge with ce=1; a result is
  // consumed when dout_valid=1 at an edge with ce=1. There is no other backpressure.

  localparam int P  = (DIN0_SIGNED == DIN1_SIGNED) ? DIN0_WIDTH + DIN1_WIDTH
                                                   : DIN0_WIDTH + DIN1_WIDTH + 1;
  localparam int SW = ACC_WIDTH + 2;
  localparam int D  = NUM_STAGE - 2;
  localparam bit RS = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);

  localparam logic signed [SW-1:0] MAX_V = RS ? (SW'(1) << (ACC_WIDTH - 1)) - SW'(1)
                                              : (SW'(1) << ACC_WIDTH) - SW'(1);
  localparam logic signed [SW-1:0] MIN_V = RS ? -(SW'(1) << (ACC_WIDTH - 1)) : '0;

  logic [DIN0_WIDTH-1:0] a_q;
  logic [DIN1_WIDTH-1:0] b_q;
  logic                  v1_q, acc1_q, last1_q;

  logic [P-1:0]          p_q [D];
  logic [D-1:0]          v_q, acc_q, last_q;

  logic [ACC_WIDTH-1:0]  acc_r;
  logic [CNT_WIDTH-1:0]  cnt_r;
  logic                  ovf_r;
  logic                  run_open;

  // Each operand gets one extra bit so a mixed-sign pair multiplies as signed x signed.
  logic signed [DIN0_WIDTH:0] a_x;
  logic signed [DIN1_WIDTH:0] b_x;
  logic signed [P-1:0]        a_p, b_p;
  logic [P-1:0]               prod_p;

  assign a_x    = {(DIN0_SIGNED != 0) && a_q[DIN0_WIDTH-1], a_q};
  assign b_x    = {(DIN1_SIGNED != 0) && b_q[DIN1_WIDTH-1], b_q};
  assign a_p    = P'(a_x);
  assign b_p    = P'(b_x);
  assign prod_p = a_p * b_p;

  logic signed [SW-1:0] prod_s, acc_s, sum_s;
  logic [ACC_WIDTH-1:0] run_acc;
  logic [CNT_WIDTH-1:0] run_cnt;
  logic                 run_ovf;

  assign prod_s = RS ? SW'($signed(p_q[D-1])) : SW'($signed({1'b0, p_q[D-1]}));
  assign acc_s  = RS ? SW'($signed(acc_r))    : SW'($signed({1'b0, acc_r}));
  assign sum_s  = acc_s + prod_s;

  // Next run state if the sample at the output stage belongs to a run.
  always_comb begin
    run_acc = sum_s[ACC_WIDTH-1:0];
    run_cnt = (cnt_r == '1) ? cnt_r : cnt_r + 1'b1;
    run_ovf = ovf_r;
    if (!run_open) begin
      run_acc = prod_s[ACC_WIDTH-1:0];
      run_cnt = CNT_WIDTH'(1);
      run_ovf = 1'b0;
    end else if (sum_s > MAX_V) begin
      run_acc = MAX_V[ACC_WIDTH-1:0];
      run_ovf = 1'b1;
    end else if (sum_s < MIN_V) begin
      run_acc = MIN_V[ACC_WIDTH-1:0];
      run_ovf = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_q        <= '0;
      b_q        <= '0;
      v1_q       <= 1'b0;
      acc1_q     <= 1'b0;
      last1_q    <= 1'b0;
      for (int i = 0; i < D; i++) p_q[i] <= '0;
      v_q        <= '0;
      acc_q      <= '0;
      last_q     <= '0;
      acc_r      <= '0;
      cnt_r      <= '0;
      ovf_r      <= 1'b0;
      run_open   <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_cnt   <= '0;
      dout_ovf   <= 1'b0;
    end else if (ce) begin
      a_q       <= din0;
      b_q       <= din1;
      v1_q      <= din_valid;
      acc1_q    <= din_acc;
      last1_q   <= din_last;
      p_q[0]    <= prod_p;
      v_q[0]    <= v1_q;
      acc_q[0]  <= acc1_q;
      last_q[0] <= last1_q;
      for (int i = 1; i < D; i++) begin
        p_q[i]    <= p_q[i-1];
        v_q[i]    <= v_q[i-1];
        acc_q[i]  <= acc_q[i-1];
        last_q[i] <= last_q[i-1];
      end
      dout_valid <= 1'b0;
      if (v_q[D-1]) begin
        if (!acc_q[D-1]) begin
          // Single product: bypasses the run state so it can sit inside an open run.
          dout       <= prod_s[ACC_WIDTH-1:0];
          dout_cnt   <= CNT_WIDTH'(1);
          dout_ovf   <= 1'b0;
          dout_valid <= 1'b1;
        end else begin
          acc_r <= run_acc;
          cnt_r <= run_cnt;
          ovf_r <= run_ovf;
          if (last_q[D-1]) begin
            dout       <= run_acc;
            dout_cnt   <= run_cnt;
            dout_ovf   <= run_ovf;
            dout_valid <= 1'b1;
            run_open   <= 1'b0;
          end else begin
            run_open   <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_postage_maxi_mul_acc_pipe.sv
// Bench: three configurations driven with one stimulus stream, each checked by a
// scoreboard fed from an arithmetic reference model of products and saturating runs.
module tb_postage_maxi_mul_acc_pipe;

  localparam int EW = 81;  // {exp_cycle[32], ovf, cnt[16], dout[32]}

  logic        clk = 1'b0;
  logic        reset_n, ce, din_valid, din_acc, din_last;
  logic [15:0] din0;
  logic [8:0]  din1;

  logic [31:0] dout0, dout2;
  logic [25:0] dout1;
  logic [15:0] cnt0, cnt1, cnt2;
  logic        v0, v1, v2, ovf0, ovf1, ovf2;

  postage_maxi_mul_acc_pipe u0 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .din_valid(din_valid), .din0(din0), .din1(din1),
    .din_acc(din_acc), .din_last(din_last), .dout(dout0), .dout_valid(v0), .dout_cnt(cnt0),
    .dout_ovf(ovf0));

  postage_maxi_mul_acc_pipe #(.ACC_WIDTH(26)) u1 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .din_valid(din_valid), .din0(din0), .din1(din1),
    .din_acc(din_acc), .din_last(din_last), .dout(dout1), .dout_valid(v1), .dout_cnt(cnt1),
    .dout_ovf(ovf1));

  postage_maxi_mul_acc_pipe #(.DIN0_SIGNED(1), .DIN1_SIGNED(1), .NUM_STAGE(5)) u2 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .din_valid(din_valid), .din0(din0), .din1(din1),
    .din_acc(din_acc), .din_last(din_last), .dout(dout2), .dout_valid(v2), .dout_cnt(cnt2),
    .dout_ovf(ovf2));

  // clock / reset
  always #5 clk = ~clk;

  int ecyc = 0;
  always @(posedge clk) if (reset_n && ce) ecyc <= ecyc + 1;

  int checks = 0;
  int failures = 0;

  logic [EW-1:0] exp_q0[$], exp_q1[$], exp_q2[$];

  longint m_acc[3];
  int     m_cnt[3];
  bit     m_ovf[3], m_open[3];

  function automatic int inst_ns(input int i);
    return (i == 2) ? 5 : 4;
  endfunction

  function automatic int inst_aw(input int i);
    return (i == 1) ? 26 : 32;
  endfunction

  function automatic bit inst_signed(input int i);
    return (i == 2);
  endfunction

  function automatic longint opval(input longint raw, input int w, input bit s);
    if (s && raw[w-1]) return raw - (longint'(1) << w);
    return raw;
  endfunction

  task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d got=%0h expected=%0h at t=%0t", name, inst, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int i, input int cyc, input bit ovf, input int cnt, input longint val);
    logic [31:0]   d;
    logic [EW-1:0] e;
    d = 32'(val & ((longint'(1) << inst_aw(i)) - 1));
    e = {32'(cyc), ovf, 16'(cnt), d};
    case (i)
      0: exp_q0.push_back(e);
      1: exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  // Reference model: one call per accepted sample, k = enabled cycle of acceptance.
  task automatic model_sample(input logic [15:0] a, input logic [8:0] b, input bit acc,
                              input bit last, input int k);
    for (int i = 0; i < 3; i++) begin
      bit     s;
      int     aw;
      longint p, hi, lo, sum;
      s  = inst_signed(i);
      aw = inst_aw(i);
      p  = opval(longint'(a), 16, s) * opval(longint'(b), 9, s);
      hi = s ? (longint'(1) << (aw - 1)) - 1 : (longint'(1) << aw) - 1;
      lo = s ? -(longint'(1) << (aw - 1)) : 0;
      if (!acc) begin
        push_exp(i, k + inst_ns(i), 1'b0, 1, p);
      end else begin
        if (!m_open[i]) begin
          m_acc[i] = p; m_cnt[i] = 1; m_ovf[i] = 1'b0; m_open[i] = 1'b1;
        end else begin
          sum = m_acc[i] + p;
          if (sum > hi) begin sum = hi; m_ovf[i] = 1'b1; end
          else if (sum < lo) begin sum = lo; m_ovf[i] = 1'b1; end
          m_acc[i] = sum;
          if (m_cnt[i] < 65535) m_cnt[i]++;
        end
        if (last) begin
          push_exp(i, k + inst_ns(i), m_ovf[i], m_cnt[i], m_acc[i]);
          m_open[i] = 1'b0;
        end
      end
    end
  endtask

  // scoreboard monitor
  task automatic check_out(input int i, input logic [31:0] d, input logic [15:0] c, input logic o);
    logic [EW-1:0] e;
    int qs;
    case (i)
      0: qs = exp_q0.size();
      1: qs = exp_q1.size();
      default: qs = exp_q2.size();
    endcase
    checks++;
    if (qs == 0) begin
      failures++;
      $display("FAIL unexpected_output inst%0d got dout=%0h cnt=%0d expected none at t=%0t", i, d, c, $time);
      return;
    end
    case (i)
      0: e = exp_q0.pop_front();
      1: e = exp_q1.pop_front();
      default: e = exp_q2.pop_front();
    endcase
    chk("dout", i, 64'(d), 64'(e[31:0]));
    chk("dout_cnt", i, 64'(c), 64'(e[47:32]));
    chk("dout_ovf", i, 64'(o), 64'(e[48]));
    chk("latency_cycle", i, 64'(ecyc), 64'(e[80:49]));
  endtask

  always @(negedge clk) begin
    if (reset_n && ce) begin
      if (v0) check_out(0, dout0, cnt0, ovf0);
      if (v1) check_out(1, 32'(dout1), cnt1, ovf1);
      if (v2) check_out(2, dout2, cnt2, ovf2);
    end
  end

  // driver tasks
  task automatic cyc_idle(input bit ce_v);
    @(posedge clk);
    #1;
    ce        = ce_v;
    din_valid = 1'b0;
    din_acc   = 1'($urandom_range(1));
    din_last  = 1'($urandom_range(1));
    din0      = 16'($urandom);
    din1      = 9'($urandom);
  endtask

  task automatic send(input logic [15:0] a, input logic [8:0] b, input bit acc, input bit last,
                      input int stall_pct);
    bit done;
    bit ce_v;
    done = 1'b0;
    while (!done) begin
      @(posedge clk);
      #1;
      ce_v      = (int'($urandom_range(99)) >= stall_pct);
      ce        = ce_v;
      din_valid = 1'b1;
      din0      = a;
      din1      = b;
      din_acc   = acc;
      din_last  = last;
      done      = ce_v;
    end
    model_sample(a, b, acc, last, ecyc);
  endtask

  task automatic drain();
    repeat (10) cyc_idle(1'b1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_dout", 0, 64'(dout0), 64'd0);
    chk("rst_dout", 1, 64'(dout1), 64'd0);
    chk("rst_dout", 2, 64'(dout2), 64'd0);
    chk("rst_valid", 0, 64'(v0), 64'd0);
    chk("rst_valid", 1, 64'(v1), 64'd0);
    chk("rst_valid", 2, 64'(v2), 64'd0);
    chk("rst_cnt", 0, 64'(cnt0), 64'd0);
    chk("rst_cnt", 1, 64'(cnt1), 64'd0);
    chk("rst_cnt", 2, 64'(cnt2), 64'd0);
    chk("rst_ovf", 0, 64'(ovf0), 64'd0);
    chk("rst_ovf", 1, 64'(ovf1), 64'd0);
    chk("rst_ovf", 2, 64'(ovf2), 64'd0);
  endtask

  // Reset held with ce low: reset must win over the frozen pipeline.
  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n   = 1'b0;
    ce        = 1'b0;
    din_valid = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) m_open[i] = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; ce = 1'b0; din_valid = 1'b0; din_acc = 1'b0; din_last = 1'b0;
    din0 = '0; din1 = '0;
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 1'b0; m_open[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_reset_outputs();

    // single product at maximum unsigned operands
    send(16'd65535, 9'd511, 1'b0, 1'b0, 0);
    drain();

    // streaming back-to-back
    for (int i = 0; i < 8; i++) send(16'(i + 1), 9'd3, 1'b0, 1'b0, 0);
    drain();

    // run with an interleaved single product
    send(16'd100, 9'd2, 1'b1, 1'b0, 0);
    send(16'd7,   9'd7, 1'b0, 1'b0, 0);
    send(16'd200, 9'd3, 1'b1, 1'b0, 0);
    send(16'd300, 9'd4, 1'b1, 1'b1, 0);
    drain();

    // ce stall with two samples in flight
    send(16'd11, 9'd13, 1'b0, 1'b0, 0);
    send(16'd17, 9'd19, 1'b0, 1'b0, 0);
    repeat (3) cyc_idle(1'b0);
    drain();

    // saturation run
    for (int i = 0; i < 3; i++) send(16'd65535, 9'd511, 1'b1, (i == 2), 0);
    drain();

    // signed operand corners
    send(16'h8000, 9'h100, 1'b0, 1'b0, 0);
    send(16'h8000, 9'h0FF, 1'b0, 1'b0, 0);
    drain();

    // reset in the middle of a run
    send(16'd9, 9'd9, 1'b1, 1'b0, 0);
    send(16'd3, 9'd4, 1'b1, 1'b0, 0);
    do_reset();
    check_reset_outputs();
    send(16'd5, 9'd5, 1'b1, 1'b1, 0);
    drain();

    // randomized mix with ce stalls and gaps
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(9) == 0) cyc_idle(1'($urandom_range(1)));
      send(16'($urandom), 9'($urandom), 1'($urandom_range(1)), ($urandom_range(3) == 0), 20);
    end
    send(16'd1, 9'd1, 1'b1, 1'b1, 0);
    drain();

    chk("queue_empty", 0, 64'(exp_q0.size()), 64'd0);
    chk("queue_empty", 1, 64'(exp_q1.size()), 64'd0);
    chk("queue_empty", 2, 64'(exp_q2.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
